// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 pixel serializer.
// Reused by the serializer and by ws2812_fade_top.
package ws2812_pkg;

    // One GRB pixel: G in [23:16], R in [15:8], B in [7:0].
    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Default timing at 50 MHz.
    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_T0H_CYCLES   = 20;
    localparam int DEF_T1H_CYCLES   = 40;
    localparam int DEF_BIT_CYCLES   = 63;
    localparam int DEF_LATCH_CYCLES = 15_000;

endpackage

// File: rtl/ws2812_serializer.sv
// WS2812 serializer: accepts 24-bit GRB pixels over valid/ready and
// emits the one-wire waveform MSB first, with an end-of-frame latch.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   pixel_data[23:0]  - GRB pixel, sampled on the transfer cycle only
//   pixel_last        - final pixel of a frame, sampled with pixel_data
//   pixel_valid       - upstream offers a pixel
//   pixel_ready       - high only in IDLE
//   ws2812_out        - registered data line
//   busy              - high in every state except IDLE
//   frame_done        - one-cycle pulse when the latch completes
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pixel_data,
    input  logic        pixel_last,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        ws2812_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int PW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(24);
    localparam int LW = $clog2(LATCH_CYCLES);

    localparam logic [PW-1:0] PH_LAST   = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] T0H_P     = PW'(T0H_CYCLES);
    localparam logic [PW-1:0] T1H_P     = PW'(T1H_CYCLES);
    localparam logic [BW-1:0] BIT_LAST  = BW'(23);
    localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_CYCLES - 1);

    state_e        state_q, state_d;
    pixel_t        shift_q, shift_d;
    logic          last_q,  last_d;
    logic [BW-1:0] bit_q,   bit_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [LW-1:0] latch_q, latch_d;
    logic          out_q,   out_d;
    logic          ready_q, ready_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [PW-1:0] high_len;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        last_d  = last_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        latch_d = latch_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pixel_valid && ready_q) begin
                    shift_d = pixel_data;
                    last_d  = pixel_last;
                    bit_d   = '0;
                    phase_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        latch_d = '0;
                        state_d = last_q ? LATCH : IDLE;
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LATCH: begin
                if (latch_q == LAT_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    latch_d = latch_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next state so that the registered
        // line tracks the phase counter with no extra cycle of lag.
        high_len = shift_d[23] ? T1H_P : T0H_P;
        out_d    = (state_d == SEND) && (phase_d < high_len);
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            last_q  <= 1'b0;
            bit_q   <= '0;
            phase_q <= '0;
            latch_q <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            latch_q <= latch_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pixel_ready = ready_q;
    assign ws2812_out  = out_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Testbench for ws2812_serializer: table vectors, scripted corner cases
// and random pixel streams checked against a waveform reference model.
module tb_ws2812_serializer;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int BITC = 63;
    localparam int LATC = 15000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pixel_data = '0;
    logic        pixel_last = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        ws2812_out;
    logic        busy;
    logic        frame_done;

    ws2812_serializer #(
        .CLK_HZ      (50000000),
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BITC),
        .LATCH_CYCLES(LATC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_data (pixel_data),
        .pixel_last (pixel_last),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .ws2812_out (ws2812_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic o;
        logic b;
        logic r;
        logic d;
    } obs_t;

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          gap;
    } offer_t;

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          exp_hi;
        int          exp_done;
    } vec_t;

    obs_t   exp_q[$];
    offer_t off_q[$];
    int     n_pass = 0;
    int     n_chk = 0;
    int     hi_cnt;
    int     done_cnt;
    int     done_seen = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_seen++;

    function automatic obs_t mk(input logic o, input logic b,
                                input logic r, input logic d);
        return obs_t'({o, b, r, d});
    endfunction

    // Expected per-cycle waveform of one accepted pixel, from the
    // transfer edge onward.
    function automatic void model_push(input logic [23:0] d, input logic last);
        for (int i = 23; i >= 0; i--)
            for (int ph = 0; ph < BITC; ph++)
                exp_q.push_back(mk(ph < (d[i] ? T1H : T0H), 1'b1, 1'b0, 1'b0));
        if (last) begin
            for (int k = 0; k < LATC; k++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Drives everything in off_q, compares every cycle to the model and
    // records one check for the whole segment.
    task automatic run_seg(input string name, input int tail_len);
        int   cyc, err, first, tail, gapc;
        obs_t a, e, fa, fe;
        hi_cnt = 0; done_cnt = 0; err = 0; first = -1;
        tail = 0; cyc = 0; fa = '0; fe = '0;
        gapc = (off_q.size() > 0) ? off_q[0].gap : 0;
        while (tail < tail_len && cyc < 40000) begin
            @(negedge clk);
            a = mk(ws2812_out, busy, pixel_ready, frame_done);
            e = (exp_q.size() > 0) ? exp_q.pop_front()
                                   : mk(1'b0, 1'b0, 1'b1, 1'b0);
            if (a !== e) begin
                if (err == 0) begin first = cyc; fa = a; fe = e; end
                err++;
            end
            if (ws2812_out === 1'b1) hi_cnt++;
            if (frame_done === 1'b1) done_cnt++;
            if (off_q.size() > 0 && gapc == 0) begin
                pixel_valid = 1'b1;
                pixel_data  = off_q[0].data;
                pixel_last  = off_q[0].last;
                if (e.r) model_push(off_q[0].data, off_q[0].last);
                if (pixel_ready === 1'b1) begin
                    void'(off_q.pop_front());
                    if (off_q.size() > 0) gapc = off_q[0].gap;
                end
            end else begin
                pixel_valid = 1'b0;
                pixel_data  = 24'($urandom);
                pixel_last  = 1'($urandom);
                if (gapc > 0) gapc--;
            end
            if (off_q.size() == 0 && exp_q.size() == 0) tail++;
            cyc++;
        end
        if (cyc >= 40000) begin
            err++;
            off_q.delete();
            exp_q.delete();
        end
        pixel_valid = 1'b0;
        n_chk++;
        if (err == 0) n_pass++;
        else $display("FAIL %s: %0d bad cycles, first at %0d got obrd=%b expected %b",
                      name, err, first, fa, fe);
    endtask

    initial begin
        vec_t vecs[6];
        int   t0, w;

        vecs[0] = '{24'hFF0000, 1'b1, 640, 1};
        vecs[1] = '{24'h000000, 1'b0, 480, 0};
        vecs[2] = '{24'hFFFFFF, 1'b0, 960, 0};
        vecs[3] = '{24'h000001, 1'b0, 500, 0};
        vecs[4] = '{24'hA5A5A5, 1'b0, 720, 0};
        vecs[5] = '{24'h800000, 1'b0, 500, 0};

        // Reset held for 3 cycles, then released.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", int'({ws2812_out, busy, pixel_ready, frame_done}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_release", int'({ws2812_out, busy, pixel_ready, frame_done}), 2);

        foreach (vecs[i]) begin
            off_q.push_back('{vecs[i].data, vecs[i].last, int'($urandom_range(0, 3))});
            run_seg($sformatf("tbl%0d_wave", i), 4);
            check($sformatf("tbl%0d_high", i), hi_cnt, vecs[i].exp_hi);
            check($sformatf("tbl%0d_done", i), done_cnt, vecs[i].exp_done);
        end

        // Back-to-back pixels with valid held high.
        off_q.push_back('{24'hA5A5A5, 1'b0, 0});
        off_q.push_back('{24'h000001, 1'b1, 0});
        run_seg("b2b_wave", 4);
        check("b2b_high", hi_cnt, 12 * T1H + 12 * T0H + 23 * T0H + T1H);
        check("b2b_done", done_cnt, 1);

        // Reset mid-frame at bit 12, phase 30.
        t0 = done_seen;
        w = 0;
        while (pixel_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        pixel_valid = 1'b1;
        pixel_data  = 24'hFFFFFF;
        pixel_last  = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_data  = 24'h0F0F0F;
        check("abort_rise", int'({ws2812_out, busy}), 3);
        repeat (11 * BITC + 30) @(negedge clk);
        check("abort_pre", int'({ws2812_out, busy}), 3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out", int'({ws2812_out, busy, pixel_ready, frame_done}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_rel", int'({ws2812_out, busy, pixel_ready, frame_done}), 2);
        off_q.push_back('{24'h5A3C0F, 1'b0, 2});
        run_seg("abort_next", 8);
        check("abort_nodone", done_seen - t0, 0);

        // Non-last pixel, then silence: line low, no frame_done.
        off_q.push_back('{24'h123456, 1'b0, 1});
        run_seg("last0_idle", 300);
        check("last0_done", done_cnt, 0);

        // Random stream with random idle gaps.
        off_q.push_back('{24'($urandom), 1'b0, 0});
        for (int i = 0; i < 11; i++)
            off_q.push_back('{24'($urandom), 1'b0, int'($urandom_range(0, 30))});
        run_seg("random_stream", 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ws2812_serializer.md
WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clock frequency in Hz, documentation only; timing constants assume 50 MHz.
REQ-002 SHALL have parameter T0H_CYCLES, default 20: high time of a 0 bit (400 ns).
REQ-003 SHALL have parameter T1H_CYCLES, default 40: high time of a 1 bit (800 ns).
REQ-004 SHALL have parameter BIT_CYCLES, default 63: total bit period (1.26 us).
REQ-005 SHALL have parameter LATCH_CYCLES, default 15000: low time of the end-of-frame latch (300 us).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port pixel_data, input, 24 bits: GRB pixel, G in [23:16], R in [15:8], B in [7:0].
REQ-009 SHALL have port pixel_last, input, 1 bit: marks the final pixel of a frame; sampled with pixel_data.
REQ-010 SHALL have port pixel_valid, input, 1 bit: upstream offers a pixel.
REQ-011 SHALL have port pixel_ready, output, 1 bit: serializer accepts a pixel this cycle.
REQ-012 SHALL have port ws2812_out, output, 1 bit: registered WS2812 data line.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the latch completes.

Function
REQ-015 SHALL implement the state machine IDLE, SEND, LATCH.
REQ-016 SHALL drive pixel_ready high only in IDLE; a transfer occurs on the cycle where pixel_valid and pixel_ready are both high.
REQ-017 SHALL, on a transfer, capture pixel_data into a 24-bit shift register, capture pixel_last, clear the bit counter and the phase counter, and enter SEND.
REQ-018 SHALL ignore pixel_data and pixel_last on every cycle other than a transfer cycle.
REQ-019 SHALL transmit MSB first, bit 23 through bit 0; each bit lasts exactly BIT_CYCLES clocks.
REQ-020 SHALL count the phase counter 0..BIT_CYCLES-1 and drive ws2812_out high while phase < (bit ? T1H_CYCLES : T0H_CYCLES), otherwise low.
REQ-021 SHALL make ws2812_out rise on the first clock edge after the transfer (latency 1 cycle).
REQ-022 SHALL, at phase = BIT_CYCLES-1 of bits 23..1, shift left, increment the bit counter and reset the phase counter to 0.
REQ-023 SHALL, at phase = BIT_CYCLES-1 of bit 0, enter LATCH if the captured last flag is 1, else enter IDLE.
REQ-024 SHALL hold ws2812_out low in IDLE; an IDLE gap between pixels extends the low phase of the previous bit, and upstream keeps such gaps below 5 us.
REQ-025 SHALL hold ws2812_out low for exactly LATCH_CYCLES clocks in LATCH, then pulse frame_done for one cycle and enter IDLE; pixel_ready goes high on the same cycle as frame_done.
REQ-026 SHALL size the counters as $clog2 of their maximum value; the counters shall not wrap.
REQ-027 SHALL treat pixel_valid with pixel_ready low as a no-op; upstream holds the pixel until it is accepted.

Reset
REQ-028 SHALL, while reset is high at a clock edge, force state IDLE, ws2812_out 0, pixel_ready 0, busy 0, frame_done 0, the shift register 0, all counters 0 and the last flag 0.
REQ-029 SHALL drive pixel_ready 1 on the first edge after reset is released.
REQ-030 SHALL abort any SEND or LATCH on reset asserted mid-operation without emitting frame_done; reset has priority over every transition.

Structure
REQ-031 SHALL place in shared package ws2812_pkg: the pixel_t 24-bit typedef, the state enum typedef and the default timing constants, for reuse by ws2812_fade_top.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL cover this scenario: reset for 3 cycles -> ws2812_out 0, busy 0, pixel_ready 1 on the cycle after release.
REQ-034 SHALL cover this scenario: pixel 0xFF0000 with last=1 -> 8 high times of 40 cycles, then 16 high times of 20 cycles, each in a 63-cycle bit; then 15000 low cycles; then a single frame_done pulse.
REQ-035 SHALL cover this scenario: two back-to-back pixels 0xA5A5A5 (last=0) and 0x000001 (last=1) with pixel_valid held high -> exactly 1 IDLE cycle between them, bit pattern 10100101 repeated, final bit high time 40 cycles.
REQ-036 SHALL cover this scenario: pixel_data toggled while busy -> no change on ws2812_out; pixel_ready stays 0 until IDLE.
REQ-037 SHALL cover this scenario: reset asserted at bit 12 phase 30 -> ws2812_out 0 next cycle, no frame_done, the next pixel transmits cleanly.
REQ-038 SHALL cover this scenario: pixel with last=0 followed by no valid -> ws2812_out stays low, busy 0, frame_done never asserted.
